// File: rtl/gray_pkg.sv
// Shared types and helpers for the gray2bin self-test sequencer.
// Defaults: 4-bit codes, one settle cycle between drive and sample.
package gray_pkg;
    localparam int GRAY_W_DEF      = 4;
    localparam int GRAY_SETTLE_DEF = 1;
    localparam int GRAY_FN_W       = 32;

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} gray_sweep_state_e;

    // Callers zero-extend and truncate, which is exact for the Gray transform.
    function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/gray_settle_timer.sv
// Loadable down-counter with zero flag; times the WAIT state of the sweep.
// Latency: load takes effect next cycle; no backpressure, saturates at zero.
module gray_settle_timer #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          zero_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/gray_sweep_ctrl.sv
// BIST sequencer: sweeps all W-bit Gray codes into a gray2bin converter and counts mismatches.
// Latency: 2**W*(2+SETTLE_CYC) busy cycles + 1 DONE cycle; start ignored while busy, abort cancels.
// Optional first-failure capture ports under GRAY_SWEEP_FAIL_LOG_EN.
module gray_sweep_ctrl
    import gray_pkg::*;
#(
    parameter int W          = GRAY_W_DEF,
    parameter int SETTLE_CYC = GRAY_SETTLE_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         pass_o,
`ifdef GRAY_SWEEP_FAIL_LOG_EN
    output logic         fail_seen_o,
    output logic [W-1:0] fail_gray_o,
    output logic [W-1:0] fail_bin_o,
`endif
    output logic [W:0]   err_cnt_o
);
    localparam int TMR_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TMR_LOAD = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
    localparam logic [W:0] ERR_MAX = {1'b1, {W{1'b0}}};

    gray_sweep_state_e state_q, state_d;
    logic [W-1:0]      idx_q, idx_d;
    logic [W-1:0]      gray_q, gray_d;
    logic [W:0]        err_q, err_d;
    logic              pass_q, pass_d;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic              start_acc, mismatch, busy;

    gray_settle_timer #(.CW(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (TMR_W'(TMR_LOAD)),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign busy = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gray_d    = gray_q;
        err_d     = err_q;
        pass_d    = pass_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        start_acc = 1'b0;
        mismatch  = 1'b0;
        case (state_q)
            IDLE: begin
                // Abort has priority over a simultaneous start.
                if (start_i && !abort_i) begin
                    start_acc = 1'b1;
                    state_d   = DRIVE;
                    idx_d     = '0;
                    err_d     = '0;
                    pass_d    = 1'b0;
                end
            end
            DRIVE: begin
                gray_d   = W'(bin2gray(GRAY_FN_W'(idx_q)));
                tmr_load = 1'b1;
                state_d  = (SETTLE_CYC > 0) ? WAIT : CHECK;
            end
            WAIT: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CHECK: begin
                mismatch = (bin_i != idx_q);
                if (mismatch && (err_q != ERR_MAX)) begin
                    err_d = err_q + 1'b1;
                end
                if (&idx_q) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            DONE: begin
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_i && busy) begin
            state_d = IDLE;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gray_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gray_q  <= gray_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

`ifdef GRAY_SWEEP_FAIL_LOG_EN
    logic         fail_seen_q, fail_seen_d;
    logic [W-1:0] fail_gray_q, fail_gray_d;
    logic [W-1:0] fail_bin_q, fail_bin_d;

    always_comb begin
        fail_seen_d = fail_seen_q;
        fail_gray_d = fail_gray_q;
        fail_bin_d  = fail_bin_q;
        if (start_acc) begin
            fail_seen_d = 1'b0;
            fail_gray_d = '0;
            fail_bin_d  = '0;
        end else if (mismatch && !fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_gray_d = gray_q;
            fail_bin_d  = bin_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen_q <= 1'b0;
            fail_gray_q <= '0;
            fail_bin_q  <= '0;
        end else begin
            fail_seen_q <= fail_seen_d;
            fail_gray_q <= fail_gray_d;
            fail_bin_q  <= fail_bin_d;
        end
    end

    assign fail_seen_o = fail_seen_q;
    assign fail_gray_o = fail_gray_q;
    assign fail_bin_o  = fail_bin_q;
`endif

    assign gray_o    = gray_q;
    assign busy_o    = busy;
    assign done_o    = (state_q == DONE);
    assign pass_o    = pass_q;
    assign err_cnt_o = err_q;
endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Directed bench for gray_sweep_ctrl: default-settle instance plus a zero-settle instance.
module tb_gray_sweep_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, abort_a, start_b, abort_b, stuck;
    logic [3:0] gray_a, bin_a, gray_b, bin_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [4:0] err_a, err_b;
`ifdef GRAY_SWEEP_FAIL_LOG_EN
    logic       fseen_a, fseen_b;
    logic [3:0] fgray_a, fbin_a, fgray_b, fbin_b;
`endif
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign bin_a = stuck ? (g2b(gray_a) & 4'b1110) : g2b(gray_a);
    assign bin_b = g2b(gray_b);

    gray_sweep_ctrl #(.W(4), .SETTLE_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a), .bin_i(bin_a),
        .gray_o(gray_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
`ifdef GRAY_SWEEP_FAIL_LOG_EN
        .fail_seen_o(fseen_a), .fail_gray_o(fgray_a), .fail_bin_o(fbin_a),
`endif
        .err_cnt_o(err_a)
    );

    gray_sweep_ctrl #(.W(4), .SETTLE_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b), .bin_i(bin_b),
        .gray_o(gray_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
`ifdef GRAY_SWEEP_FAIL_LOG_EN
        .fail_seen_o(fseen_b), .fail_gray_o(fgray_b), .fail_bin_o(fbin_b),
`endif
        .err_cnt_o(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Samples the current cycle first; stops one cycle after done_a so pass_a is visible.
    task automatic watch_a(output int busy_cnt, output int done_cnt, output logic pass_seen);
        busy_cnt  = 0;
        done_cnt  = 0;
        pass_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy_a) busy_cnt++;
            if (done_a) begin
                done_cnt++;
                tick();
                pass_seen = pass_a;
                if (done_a) done_cnt++;
                break;
            end
            tick();
        end
    endtask

    int   bc, dc, bc_b;
    logic ps;
    logic [3:0] gtbl [16];

    initial begin
        gtbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        rst_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0; stuck = 1'b0;
        #2;
        check("rst_gray", gray_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: ideal converter
        start_a = 1'b1; tick(); start_a = 1'b0;
        watch_a(bc, dc, ps);
        check("t1_busy_cycles", bc, 48);
        check("t1_done_pulses", dc, 1);
        check("t1_pass", ps, 1);
        check("t1_err", err_a, 0);
        check("t1_gray_hold", gray_a, 4'h8);

        // 2: bin_i[0] stuck at 0
        stuck = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("t2_pass_cleared", pass_a, 0);
        watch_a(bc, dc, ps);
        check("t2_busy_cycles", bc, 48);
        check("t2_done_pulses", dc, 1);
        check("t2_pass", ps, 0);
        check("t2_err", err_a, 8);
`ifdef GRAY_SWEEP_FAIL_LOG_EN
        check("t2_fail_seen", fseen_a, 1);
        check("t2_fail_gray", fgray_a, 4'b0001);
        check("t2_fail_bin", fbin_a, 4'b0000);
`endif

        // 3: abort at sweep cycle 10 (WAIT of idx 3, one mismatch so far)
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t3_busy_before", busy_a, 1);
        abort_a = 1'b1; tick(); abort_a = 1'b0;
        check("t3_busy", busy_a, 0);
        check("t3_done", done_a, 0);
        check("t3_pass", pass_a, 0);
        check("t3_err_partial", err_a, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_no_done", {busy_a, done_a}, 2'b00);
        end
        stuck = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        watch_a(bc, dc, ps);
        check("t3_re_busy", bc, 48);
        check("t3_re_done", dc, 1);
        check("t3_re_pass", ps, 1);
`ifdef GRAY_SWEEP_FAIL_LOG_EN
        check("t3_fail_seen_clr", fseen_a, 0);
`endif

        // 4: start held high across the sweep
        start_a = 1'b1; tick();
        watch_a(bc, dc, ps);
        check("t4_busy_cycles", bc, 48);
        check("t4_done_pulses", dc, 1);
        check("t4_pass", ps, 1);
        tick();
        check("t4_second_busy", busy_a, 1);
        check("t4_second_pass_clr", pass_a, 0);
        start_a = 1'b0;
        watch_a(bc, dc, ps);
        check("t4_second_cycles", bc, 48);
        check("t4_second_pass", ps, 1);

        // 5: async reset while in WAIT of idx 2 (gray_o=3, err=1)
        stuck = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("t5_pre_gray", gray_a, 4'h3);
        check("t5_pre_err", err_a, 1);
        rst_n = 1'b0;
        #2;
        check("t5_gray", gray_a, 0);
        check("t5_busy", busy_a, 0);
        check("t5_done", done_a, 0);
        check("t5_err", err_a, 0);
        check("t5_pass", pass_a, 0);
        tick();
        check("t5_held_busy", busy_a, 0);
        rst_n = 1'b1; stuck = 1'b0;
        tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        watch_a(bc, dc, ps);
        check("t5_busy_cycles", bc, 48);
        check("t5_pass", ps, 1);
        check("t5_err_final", err_a, 0);

        // 6: zero settle cycles, gray_o checked every CHECK cycle
        bc_b = 0;
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (busy_b) bc_b++;
            tick();
            if (busy_b) bc_b++;
            check($sformatf("t6_gray_%0d", k), gray_b, gtbl[k]);
            tick();
        end
        check("t6_busy_cycles", bc_b, 32);
        check("t6_done", {done_b, busy_b}, 2'b10);
        tick();
        check("t6_done_gone", done_b, 0);
        check("t6_pass", pass_b, 1);
        check("t6_err", err_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
